// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: one-cycle hits, 4-word burst refill on a miss,
// whole-cache invalidate and saturating hit/miss counters.
module dm_cache_ctrl #(
  parameter int unsigned ADDR_W   = 15,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned OFFSET_W = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              inv,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned TagW  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned Lines = 2 ** INDEX_W;
  localparam int unsigned Words = 2 ** OFFSET_W;

  typedef enum logic [1:0] {StIdle, StRefill, StRespond} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]  valid_q;
  logic [TagW-1:0]   tag_mem  [Lines];
  logic [DATA_W-1:0] data_mem [Lines*Words];

  logic [TagW-1:0]     req_tag_q;
  logic [INDEX_W-1:0]  req_idx_q;
  logic [OFFSET_W-1:0] req_off_q;
  logic [OFFSET_W:0]   rcnt_q;
  logic                rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    hit_q, miss_q;

  logic [TagW-1:0]     addr_tag;
  logic [INDEX_W-1:0]  addr_idx;
  logic [OFFSET_W-1:0] addr_off;
  logic                lookup_hit, accept, hit_acc, miss_acc;
  logic                issue_en, wr_en, refill_done;
  logic [OFFSET_W-1:0] wr_off;

  assign addr_tag = cpu_addr[ADDR_W-1 -: TagW];
  assign addr_idx = cpu_addr[OFFSET_W +: INDEX_W];
  assign addr_off = cpu_addr[OFFSET_W-1:0];

  assign cpu_ready  = (state_q == StIdle) && !inv;
  assign lookup_hit = valid_q[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign accept     = cpu_req && cpu_ready;
  assign hit_acc    = accept && lookup_hit;
  assign miss_acc   = accept && !lookup_hit;

  // rcnt_q doubles as issue counter (0..Words-1) and, lagging by one, the write counter.
  assign issue_en    = (state_q == StRefill) && !rcnt_q[OFFSET_W];
  assign wr_en       = (state_q == StRefill) && (rcnt_q != '0);
  assign wr_off      = rcnt_q[OFFSET_W-1:0] - OFFSET_W'(1);
  assign refill_done = (state_q == StRefill) && rcnt_q[OFFSET_W];

  assign mem_addr   = issue_en ? {req_tag_q, req_idx_q, rcnt_q[OFFSET_W-1:0]} : '0;
  assign cpu_rvalid = rvalid_q;
  assign cpu_rdata  = rdata_q;
  assign hit_cnt    = hit_q;
  assign miss_cnt   = miss_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (miss_acc) state_d = StRefill;
      StRefill:  if (refill_done) state_d = StRespond;
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      valid_q   <= '0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rcnt_q    <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      req_tag_q <= '0;
      req_idx_q <= '0;
      req_off_q <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= hit_acc || refill_done;

      if (hit_acc) begin
        rdata_q <= data_mem[{addr_idx, addr_off}];
      end else if (wr_en && (wr_off == req_off_q)) begin
        rdata_q <= mem_rdata;
      end

      if ((state_q == StIdle) && inv) begin
        valid_q <= '0;
      end else if (miss_acc) begin
        valid_q[addr_idx] <= 1'b0;
      end else if (refill_done) begin
        valid_q[req_idx_q] <= 1'b1;
      end

      if (miss_acc) begin
        req_tag_q <= addr_tag;
        req_idx_q <= addr_idx;
        req_off_q <= addr_off;
      end

      if ((state_q == StRefill) && !refill_done) begin
        rcnt_q <= rcnt_q + (OFFSET_W + 1)'(1);
      end else begin
        rcnt_q <= '0;
      end

      if (hit_acc && (hit_q != '1)) hit_q <= hit_q + CNT_W'(1);
      if (miss_acc && (miss_q != '1)) miss_q <= miss_q + CNT_W'(1);
    end
  end

  // Line storage carries no reset; valid_q alone decides whether contents are usable.
  always_ff @(posedge clk) begin
    if (wr_en) data_mem[{req_idx_q, wr_off}] <= mem_rdata;
    if (refill_done) tag_mem[req_idx_q] <= req_tag_q;
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: per-cycle vector table plus hand-written sequences
// for reset-during-refill, held requests and counter saturation. Memory model: mem[a] = a.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [14:0] cpu_addr;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        inv;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Registered-read memory with mem[a] = a.
  always @(posedge clk) mem_rdata <= {17'd0, mem_addr};

  dm_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_ready  (cpu_ready),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .inv        (inv),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        inv;
    logic [14:0] addr;
    logic        ready;
    logic        rvalid;
    logic        chk_data;
    logic [31:0] rdata;
    logic [14:0] maddr;
  } vec_t;

  vec_t vq[$];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle and advance to the negedge, where outputs are sampled.
  task automatic drive(input logic r, input logic q, input logic i, input logic [14:0] a);
    rst = r; cpu_req = q; inv = i; cpu_addr = a;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic q, input logic i, input logic [14:0] a, input logic rdy,
                     input logic rv, input logic chk, input logic [31:0] d,
                     input logic [14:0] ma);
    vec_t v;
    v.rst = 1'b0; v.req = q; v.inv = i; v.addr = a;
    v.ready = rdy; v.rvalid = rv; v.chk_data = chk; v.rdata = d; v.maddr = ma;
    vq.push_back(v);
  endtask

  // Seven cycles of a miss: accept, four burst issues, last write, respond.
  task automatic add_miss(input logic [14:0] a, input logic [31:0] prev);
    logic [14:0] base;
    base = a & 15'h7ffc;
    add(1'b1, 1'b0, a, 1'b1, 1'b0, 1'b1, prev, 15'h0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 32'h0, base + 15'(k));
    add(1'b0, 1'b0, 15'h0, 1'b0, 1'b0, 1'b0, 32'h0, 15'h0);
    add(1'b0, 1'b0, 15'h0, 1'b0, 1'b1, 1'b1, {17'd0, a}, 15'h0);
  endtask

  task automatic run_table();
    foreach (vq[n]) begin
      drive(vq[n].rst, vq[n].req, vq[n].inv, vq[n].addr);
      cmp($sformatf("row%0d ready", n), {31'd0, cpu_ready}, {31'd0, vq[n].ready});
      cmp($sformatf("row%0d rvalid", n), {31'd0, cpu_rvalid}, {31'd0, vq[n].rvalid});
      cmp($sformatf("row%0d mem_addr", n), {17'd0, mem_addr}, {17'd0, vq[n].maddr});
      if (vq[n].chk_data) cmp($sformatf("row%0d rdata", n), cpu_rdata, vq[n].rdata);
      next_cycle();
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; inv = 1'b0; cpu_addr = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state, cold miss on 0x5, then three hits back to back.
    add(1'b0, 1'b0, 15'h0, 1'b1, 1'b0, 1'b1, 32'h0, 15'h0);
    add_miss(15'h0005, 32'h0);
    add(1'b1, 1'b0, 15'h0006, 1'b1, 1'b0, 1'b1, 32'h5, 15'h0);
    add(1'b1, 1'b0, 15'h0007, 1'b1, 1'b1, 1'b1, 32'h6, 15'h0);
    add(1'b1, 1'b0, 15'h0004, 1'b1, 1'b1, 1'b1, 32'h7, 15'h0);
    add(1'b0, 1'b0, 15'h0000, 1'b1, 1'b1, 1'b1, 32'h4, 15'h0);
    add(1'b0, 1'b0, 15'h0000, 1'b1, 1'b0, 1'b1, 32'h4, 15'h0);
    // Index-1 conflict: 0x85 evicts 0x5, then 0x5 evicts 0x85.
    add_miss(15'h0085, 32'h4);
    add_miss(15'h0005, 32'h85);
    // Invalidate wins over a simultaneous request; the retry then misses.
    add(1'b1, 1'b1, 15'h0006, 1'b0, 1'b0, 1'b1, 32'h5, 15'h0);
    add_miss(15'h0006, 32'h5);

    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("reset hit_cnt", {16'd0, hit_cnt}, 32'd0);
    cmp("reset miss_cnt", {16'd0, miss_cnt}, 32'd0);
    next_cycle();

    run_table();

    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("table hit_cnt", {16'd0, hit_cnt}, 32'd3);
    cmp("table miss_cnt", {16'd0, miss_cnt}, 32'd4);
    next_cycle();

    // Reset in the middle of a refill for 0x10.
    drive(1'b0, 1'b1, 1'b0, 15'h0010);
    cmp("rstref accept", {31'd0, cpu_ready}, 32'd1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("rstref maddr0", {17'd0, mem_addr}, 32'h10);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("rstref maddr1", {17'd0, mem_addr}, 32'h11);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 15'h0);
    cmp("rstref maddr2", {17'd0, mem_addr}, 32'h12);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("after rst ready", {31'd0, cpu_ready}, 32'd1);
    cmp("after rst rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cmp("after rst rdata", cpu_rdata, 32'd0);
    cmp("after rst maddr", {17'd0, mem_addr}, 32'd0);
    cmp("after rst hit_cnt", {16'd0, hit_cnt}, 32'd0);
    cmp("after rst miss_cnt", {16'd0, miss_cnt}, 32'd0);
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, 1'b0, 1'b0, 15'h0);
      cmp($sformatf("aborted rvalid c%0d", k), {31'd0, cpu_rvalid}, 32'd0);
      next_cycle();
    end

    // Re-request 0x10 (miss) while the CPU then holds 0x11 through the refill.
    drive(1'b0, 1'b1, 1'b0, 15'h0010);
    cmp("rereq ready", {31'd0, cpu_ready}, 32'd1);
    next_cycle();
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, 1'b0, 15'h0011);
      cmp($sformatf("held ready T+%0d", k), {31'd0, cpu_ready}, 32'd0);
      cmp($sformatf("held rvalid T+%0d", k), {31'd0, cpu_rvalid}, {31'd0, k == 6});
      if (k == 6) cmp("rereq rdata", cpu_rdata, 32'h10);
      next_cycle();
    end
    drive(1'b0, 1'b1, 1'b0, 15'h0011);
    cmp("held accept ready", {31'd0, cpu_ready}, 32'd1);
    cmp("held accept rvalid", {31'd0, cpu_rvalid}, 32'd0);
    cmp("held hit_cnt", {16'd0, hit_cnt}, 32'd0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 15'h0011);
    cmp("held hit rvalid", {31'd0, cpu_rvalid}, 32'd1);
    cmp("held hit rdata", cpu_rdata, 32'h11);
    cmp("held hit_cnt after", {16'd0, hit_cnt}, 32'd1);
    cmp("held miss_cnt", {16'd0, miss_cnt}, 32'd1);
    next_cycle();

    // Keep hitting well past 2^16-1 to exercise saturation.
    for (int k = 0; k < 65540; k++) begin
      drive(1'b0, 1'b1, 1'b0, 15'h0011);
      next_cycle();
    end
    drive(1'b0, 1'b0, 1'b0, 15'h0);
    cmp("hit_cnt saturated", {16'd0, hit_cnt}, 32'hffff);
    cmp("miss_cnt unchanged", {16'd0, miss_cnt}, 32'd1);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Read-only, direct-mapped cache controller between the CPU load port and the word-addressed data memory (15-bit address, 32-bit data, 1-cycle registered read).
- Looks up each CPU read in an internal tag/valid/data array and returns hits in one cycle.
- On a miss, sequences a 4-word burst refill from data memory, then returns the requested word.
- Provides a whole-cache invalidate and saturating hit/miss counters for performance measurement.

Parameters:
- ADDR_W, 15, word-address width (matches data memory).
- DATA_W, 32, data width.
- INDEX_W, 5, line index bits (32 lines).
- OFFSET_W, 2, word-in-line bits (4 words/line). Tag width = ADDR_W-INDEX_W-OFFSET_W = 8.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  read request valid.
- cpu_addr  in  ADDR_W  request word address; sampled only on accept.
- cpu_ready  out  1  controller can accept; combinational = (state==IDLE) && !inv.
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata valid.
- cpu_rdata  out  DATA_W  read data.
- inv  in  1  invalidate all lines; honoured only in IDLE.
- mem_addr  out  ADDR_W  address to data memory.
- mem_rdata  in  DATA_W  data memory output; holds mem[addr presented on the previous cycle].
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Address split: tag = cpu_addr[14:7], index = [6:2], offset = [1:0].
- Accept condition: cpu_req && cpu_ready, in cycle T.
- States: IDLE, REFILL, RESPOND.
- Reset, synchronous:
  - state=IDLE, all valid bits 0, cpu_rvalid=0, cpu_rdata=0, mem_addr=0, counters=0, refill counters=0.
  - Tag/data arrays need not be cleared.
  - Reset mid-refill aborts the refill: line stays invalid, no cpu_rvalid is produced.
- IDLE:
  - Lookup is combinational on cpu_addr against the valid/tag arrays.
  - Hit at T: cpu_rvalid=1 and cpu_rdata=line word at T+1; hit_cnt++; stay IDLE. Back-to-back hits sustain 1 per cycle.
  - Miss at T: latch tag, index, offset; clear the line's valid bit; miss_cnt++; go REFILL.
  - inv=1: clear all valid bits at the clock edge, cpu_ready=0, no request accepted. inv has priority over cpu_req.
- REFILL:
  - Issue counter i=0..3: mem_addr={tag,index,i} during cycles T+1..T+4.
  - Write counter j=0..3: write mem_rdata into word j of the line at the ends of cycles T+2..T+5.
  - Capture mem_rdata into cpu_rdata when j==latched offset.
  - At end of T+5: set valid, write tag, go RESPOND.
  - mem_addr=0 in all other states.
- RESPOND (T+6): cpu_rvalid=1 with the requested word; next state IDLE. cpu_ready is low here.
- Miss latency: accept T -> cpu_rvalid T+6. Next accept possible at T+7.
- cpu_rvalid is 0 in every cycle not listed above. cpu_rdata holds its last value when cpu_rvalid=0.
- inv asserted outside IDLE is ignored (not queued).
- Counters saturate at 2^CNT_W-1 and do not wrap.
- A request held on cpu_req while cpu_ready=0 is not accepted or counted. The CPU keeps it asserted.

Test Plan:
All scenarios use a bench memory model with a 1-cycle registered read, mem[a]=a, unaffected by rst.
- Reset, then req 0x0005 at T -> mem_addr 0x0004,0x0005,0x0006,0x0007 at T+1..T+4; cpu_rvalid at T+6 only, cpu_rdata=0x00000005; miss_cnt=1, hit_cnt=0.
- Then req 0x0006, 0x0007, 0x0004 on consecutive cycles -> rvalid on 3 consecutive cycles, data 6, 7, 4; hit_cnt=3; mem_addr stays 0.
- Conflict on index 1:
  - req 0x0085 -> miss, burst 0x0084..0x0087, rdata 0x85.
  - Then req 0x0005 -> miss again, rdata 5; miss_cnt increments each time.
- inv pulse in IDLE with cpu_req=1 and addr 0x0006 in the same cycle -> cpu_ready=0, no accept. Next cycle req 0x0006 -> miss, 6-cycle latency, rdata 6.
- rst asserted at T+3 of a refill for 0x0010 -> next cycle state IDLE, cpu_rvalid=0, counters 0, mem_addr 0. Re-request 0x0010 -> miss, rdata 0x10 at T'+6.
- cpu_req held high through a refill with addr 0x0011 after a miss on 0x0010 -> cpu_ready low T+1..T+6. Accept at T+7 is a hit, rvalid T+8, rdata 0x11.
